// File: rtl/uart_send_pkg.sv
// rtl/uart_send_pkg.sv - shared types and constants for the uart_send transmitter
package uart_send_pkg;

  localparam int   DEFAULT_DATA_BITS = 8;
  localparam logic TXD_IDLE          = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - synchronise clk_baud and turn each rising edge into a one-cycle tick
module uart_baud_tick #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sample,
  input  logic rst,
  input  logic clk_baud,
  output logic baud_tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset low so a clk_baud already high at release is not mistaken for an edge.
  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_baud};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign baud_tick = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/uart_send_tx.sv
// rtl/uart_send_tx.sv - 8N1 UART transmitter on clk_sample; optional parity bit via UART_SEND_PARITY_EN
module uart_send_tx
  import uart_send_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
`ifdef UART_SEND_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk_sample,
  input  logic                 rst,
  input  logic                 clk_baud,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wrn,
  output logic                 txd,
  output logic                 send_over
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                   baud_tick;
  logic [SYNC_STAGES-1:0] wrn_sync_q;
  logic                   wrn_prev_q;
  logic                   wr_fall;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   txd_q, txd_d;
  logic                   send_over_q, send_over_d;
`ifdef UART_SEND_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  uart_baud_tick #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_baud_tick (
    .clk_sample (clk_sample),
    .rst        (rst),
    .clk_baud   (clk_baud),
    .baud_tick  (baud_tick)
  );

  // wrn flops reset high, so a strobe already low at release reads as one falling edge.
  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      wrn_sync_q <= '1;
      wrn_prev_q <= 1'b1;
    end else begin
      wrn_sync_q <= {wrn_sync_q[SYNC_STAGES-2:0], wrn};
      wrn_prev_q <= wrn_sync_q[SYNC_STAGES-1];
    end
  end

  assign wr_fall = wrn_prev_q & ~wrn_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_sample or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shreg_q     <= '0;
      txd_q       <= TXD_IDLE;
      send_over_q <= 1'b0;
`ifdef UART_SEND_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shreg_q     <= shreg_d;
      txd_q       <= txd_d;
      send_over_q <= send_over_d;
`ifdef UART_SEND_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shreg_d     = shreg_q;
    txd_d       = txd_q;
    send_over_d = 1'b0;
`ifdef UART_SEND_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        txd_d = TXD_IDLE;
        if (wr_fall) begin
          shreg_d = din;
          state_d = ARM;
`ifdef UART_SEND_PARITY_EN
          parity_d = (^din) ^ PARITY_ODD;
`endif
        end
      end
      ARM: begin
        if (baud_tick) begin
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          txd_d     = shreg_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (32'(bit_cnt_q) < DATA_BITS - 1) begin
            shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
            txd_d     = shreg_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
`ifdef UART_SEND_PARITY_EN
            state_d    = PARITY;
            txd_d      = parity_q;
`else
            state_d    = STOP;
            txd_d      = TXD_IDLE;
            stop_cnt_d = 1'b0;
`endif
          end
        end
      end
`ifdef UART_SEND_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d    = STOP;
          txd_d      = TXD_IDLE;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (32'(stop_cnt_q) + 1 < STOP_BITS) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d     = IDLE;
            send_over_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = TXD_IDLE;
      end
    endcase
  end

  assign txd       = txd_q;
  assign send_over = send_over_q;

endmodule

// File: tb/tb_uart_send_tx.sv
// tb/tb_uart_send_tx.sv - directed self-checking bench for uart_send_tx (UART_SEND_PARITY_EN aware)
`timescale 1ns/1ps
module tb_uart_send_tx;

`ifdef UART_SEND_PARITY_EN
  localparam int FRAME_NS = 11 * 320;
`else
  localparam int FRAME_NS = 10 * 320;
`endif

  logic       clk_sample = 1'b0;
  logic       clk_baud   = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       wrn;
  logic       txd;
  logic       send_over;

  int n_checks = 0;
  int n_err    = 0;
  int so_cnt   = 0;
  int low_cnt  = 0;

  always #10  clk_sample = ~clk_sample;
  always #160 clk_baud   = ~clk_baud;

  uart_send_tx dut (
    .clk_sample (clk_sample),
    .rst        (rst),
    .clk_baud   (clk_baud),
    .din        (din),
    .wrn        (wrn),
    .txd        (txd),
    .send_over  (send_over)
  );

  always @(negedge clk_sample) begin
    if (send_over === 1'b1) so_cnt++;
    if (txd === 1'b0) low_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Find the start bit, sample every bit mid-period, then wait for the completion pulse.
  task automatic rx_frame(input string tag, input logic [7:0] exp);
    int         n;
    time        t0;
    logic [7:0] d;
    n = 0;
    do begin
      @(negedge clk_sample);
      n++;
    end while (txd !== 1'b0 && n < 5000);
    chk({tag, "_start_seen"}, 32'(n < 5000), 1);
    if (n >= 5000) return;
    t0 = $time;
    #160;
    chk({tag, "_start_bit"}, 32'(txd), 0);
    for (int i = 0; i < 8; i++) begin
      #320;
      d[i] = txd;
    end
    chk({tag, "_data"}, 32'(d), 32'(exp));
`ifdef UART_SEND_PARITY_EN
    #320;
    chk({tag, "_parity"}, 32'(txd), 32'(^exp));
`endif
    #320;
    chk({tag, "_stop_bit"}, 32'(txd), 1);
    n = 0;
    while (send_over !== 1'b1 && n < 100) begin
      @(negedge clk_sample);
      n++;
    end
    chk({tag, "_send_over_seen"}, 32'(n < 100), 1);
    chk({tag, "_frame_ns"}, 32'($time - t0), 32'(FRAME_NS));
    #1;
  endtask

  initial begin
    int so0, lc0, bad, n;
    rst = 1'b0;
    wrn = 1'b0;
    din = 8'h4A;

    bad = 0;
    repeat (5) begin
      @(negedge clk_sample);
      if (txd !== 1'b1 || send_over !== 1'b0) bad++;
    end
    chk("reset_hold_bad_cycles", 32'(bad), 0);
    chk("reset_txd", 32'(txd), 1);

    // wrn already low at release: exactly one frame expected
    @(negedge clk_sample);
    rst = 1'b1;
    so0 = so_cnt;
    rx_frame("basic", 8'h4A);
    chk("basic_so_count", 32'(so_cnt - so0), 1);

    so0 = so_cnt;
    lc0 = low_cnt;
    #20000;
    chk("noretrig_low_cycles", 32'(low_cnt - lc0), 0);
    chk("noretrig_so_count", 32'(so_cnt - so0), 0);

    @(negedge clk_sample);
    wrn = 1'b1;
    repeat (4) @(negedge clk_sample);
    wrn = 1'b0;
    so0 = so_cnt;
    fork
      rx_frame("busy", 8'h4A);
      begin
        #1280;
        din = 8'hFF;
        wrn = 1'b1;
        repeat (3) @(negedge clk_sample);
        wrn = 1'b0;
      end
    join
    lc0 = low_cnt;
    #3000;
    chk("busy_so_count", 32'(so_cnt - so0), 1);
    chk("busy_no_second_frame", 32'(low_cnt - lc0), 0);

    @(negedge clk_sample);
    wrn = 1'b1;
    din = 8'h55;
    repeat (3) @(negedge clk_sample);
    wrn = 1'b0;
    so0 = so_cnt;
    rx_frame("b2b_first", 8'h55);
    wrn = 1'b1;
    din = 8'hA3;
    @(negedge clk_sample);
    wrn = 1'b0;
    rx_frame("b2b_second", 8'hA3);
    chk("b2b_so_count", 32'(so_cnt - so0), 2);

    @(negedge clk_sample);
    wrn = 1'b1;
    din = 8'h4A;
    repeat (3) @(negedge clk_sample);
    wrn = 1'b0;
    n = 0;
    do begin
      @(negedge clk_sample);
      n++;
    end while (txd !== 1'b0 && n < 5000);
    chk("midrst_start_seen", 32'(n < 5000), 1);
    #(160 + 320 * 5);
    chk("midrst_data_bit4", 32'(txd), 0);
    so0 = so_cnt;
    #5;
    rst = 1'b0;
    #1;
    chk("midrst_txd_async", 32'(txd), 1);
    wrn = 1'b1;
    #100;
    @(negedge clk_sample);
    rst = 1'b1;
    #2000;
    chk("midrst_no_send_over", 32'(so_cnt - so0), 0);
    chk("midrst_txd_idle", 32'(txd), 1);

    @(negedge clk_sample);
    din = 8'hC3;
    wrn = 1'b0;
    so0 = so_cnt;
    rx_frame("after_rst", 8'hC3);
    chk("after_rst_so_count", 32'(so_cnt - so0), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_send_tx.md
Name: uart_send_tx

Overview:
- Byte-wide UART transmitter in the RS-422 link datapath. Serialises an 8-bit word onto txd as an 8N1 frame, LSB first.
- Runs entirely on clk_sample. clk_baud is a slow free-running input, 16x slower in the system (320 ns vs 20 ns). It is synchronised and edge-detected into a one-cycle baud tick.
- Sits between the host write interface (din/wrn) and the 422 line driver. send_over reports frame completion.

Parameters:
- DATA_BITS, 8: data bits per frame, sent LSB first.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- SYNC_STAGES, 2: flip-flop stages used to synchronise clk_baud and wrn.

Ports:
- clk_sample  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- clk_baud  in  1  baud-rate square wave, treated as asynchronous data; each rising edge is one baud tick.
- din  in  DATA_BITS  parallel byte to send; captured on an accepted write.
- wrn  in  1  write strobe, active-low; a falling edge requests a send.
- txd  out  1  serial output; idles high.
- send_over  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Interface decision: one clock (clk_sample); reset rst is asynchronous and active-low.
- Reset values:
  - txd=1, send_over=0, state=IDLE, bit counter=0, shift register=0.
  - All synchroniser flops reset to 1, except the clk_baud synchroniser, which resets to 0.
  - Consequence: wrn already low when rst releases counts as a falling edge and triggers exactly one send.
- Baud tick: rising edge of synchronised clk_baud. It is one clk_sample cycle wide and lags the raw edge by SYNC_STAGES+1 cycles.
- Write accept:
  - Condition: synchronised wrn goes 1->0 while state==IDLE.
  - Action: latch din into the shift register and go to ARM.
  - Falling edges in any other state are ignored; no queuing.
  - wrn held low does not retrigger.
- State machine, all transitions on baud tick only:
  - ARM -> START: drive txd=0.
  - START -> DATA: drive txd=shreg[0], bit_cnt=0.
  - DATA, bit_cnt<DATA_BITS-1: shift right, txd=next bit, bit_cnt++.
  - DATA, last bit -> STOP: drive txd=1, stop_cnt=0.
  - STOP, stop_cnt<STOP_BITS-1: stop_cnt++.
  - STOP, last stop -> IDLE: send_over=1 for one clk_sample cycle; txd stays 1.
- Each bit lasts exactly one clk_baud period. The frame occupies 10 baud ticks from ARM to send_over (8N1).
- txd is registered, glitch-free, and changes only in the cycle after a tick.
- din may change after acceptance without affecting the frame in flight.
- Back-to-back: a wrn falling edge in the send_over cycle or later is accepted, since state is IDLE by then.
- Reset mid-frame: txd goes to 1 immediately and asynchronously, FSM returns to IDLE, no send_over pulse.
- If clk_baud stops, the FSM holds its state indefinitely; there is no timeout.

Optional Feature:
- Macro UART_SEND_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and drives one parity bit for one baud period.
  - Parameter PARITY_ODD (default 0) selects the sense: even parity = XOR of data bits; odd = inverted.
  - Frame becomes 11 ticks.
- Undefined: no PARITY state, no PARITY_ODD parameter, pure 8N1.

Decomposition:
- Package uart_send_pkg:
  - State enum: IDLE, ARM, START, DATA, PARITY, STOP.
  - Constant DEFAULT_DATA_BITS=8.
  - Constant TXD_IDLE=1'b1.
- Sub-module uart_baud_tick: SYNC_STAGES synchroniser plus rising-edge detector on clk_baud, producing baud_tick.
- Synchronisation and falling-edge detection of wrn stay inline in uart_send_tx.

Test Plan:
- Reset hold: rst=0 for 100 ns with clk_baud running -> txd=1, send_over=0 throughout.
- Basic frame:
  - Stimulus: wrn low, then rst released, din=8'h4A.
  - Expected txd per clk_baud period: 0 | 0,1,0,1,0,0,1,0 | 1.
  - One send_over pulse about 10x320 ns after the first tick; txd then stays 1.
- No retrigger: wrn held low 20 us after the frame -> no further start bit, no second send_over.
- Busy ignore: second wrn falling edge with din=8'hFF mid-frame -> frame still carries 0x4A, single send_over.
- Back-to-back: 8'h55 then 8'hA3, second wrn falling edge right after the first send_over -> two complete frames, two pulses.
- Reset mid-frame: rst low during data bit 4 -> txd=1 within the reset assertion, no send_over. A new write after release sends a full frame.
- Parity (UART_SEND_PARITY_EN): 8'h4A, PARITY_ODD=0 -> parity bit 1; PARITY_ODD=1 -> 0; frame is 11 ticks.
